// File: rtl/pipelined_adder_if.sv
// Stream interface for pipelined_adder: operand handshake in, result handshake out.
// Optional subtract-select line exists only when PIPELINED_ADDER_SUB_EN is defined.
interface pipelined_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
`ifdef PIPELINED_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

`ifdef PIPELINED_ADDER_SUB_EN
  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, overflow
  );
  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, overflow
  );
`else
  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, overflow
  );
  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, overflow
  );
`endif
endinterface

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder split into SEG-bit ripple segments, one register stage per segment,
// with valid/ready flow control. PIPELINED_ADDER_SUB_EN adds a per-operation subtract select.
module pipelined_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input logic              clk,
  input logic              rst_n,
  pipelined_adder_if.slave bus
);
  localparam int NSTAGES = WIDTH / SEG;
  localparam int LAST    = NSTAGES - 1;
  localparam int MSB     = WIDTH - 1;

  if (WIDTH < 1 || SEG < 1 || (WIDTH % SEG) != 0) begin : g_param_check
    $error("pipelined_adder: WIDTH must be >= 1 and a multiple of SEG");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // Subtraction is folded into the operands at entry, so the stages only ever add.
`ifdef PIPELINED_ADDER_SUB_EN
  assign b_eff = bus.sub ? ~bus.b : bus.b;
  assign c_eff = bus.sub ? ~bus.c_in : bus.c_in;
`else
  assign b_eff = bus.b;
  assign c_eff = bus.c_in;
`endif

  logic [WIDTH-1:0] a_reg     [NSTAGES];
  logic [WIDTH-1:0] b_reg     [NSTAGES];
  logic [WIDTH-1:0] s_reg     [NSTAGES];
  logic             carry_reg [NSTAGES];
  logic             valid_reg [NSTAGES];
  logic             ovf_reg;

  logic [WIDTH-1:0] a_next     [NSTAGES];
  logic [WIDTH-1:0] b_next     [NSTAGES];
  logic [WIDTH-1:0] s_next     [NSTAGES];
  logic             carry_next [NSTAGES];
  logic             valid_next [NSTAGES];
  logic             ovf_next;

  // Whole pipeline moves in lockstep; a stalled output freezes every stage, bubbles included.
  assign adv          = !valid_reg[LAST] || bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar gi = 0; gi < NSTAGES; gi++) begin : g_stage
    logic [WIDTH-1:0] a_prev;
    logic [WIDTH-1:0] b_prev;
    logic [WIDTH-1:0] s_prev;
    logic             c_prev;
    logic             v_prev;
    logic [SEG:0]     seg_add;
    logic [WIDTH-1:0] s_tmp;

    if (gi == 0) begin : g_first
      assign a_prev = bus.a;
      assign b_prev = b_eff;
      assign s_prev = '0;
      assign c_prev = c_eff;
      assign v_prev = bus.in_valid;
    end else begin : g_chain
      assign a_prev = a_reg[gi-1];
      assign b_prev = b_reg[gi-1];
      assign s_prev = s_reg[gi-1];
      assign c_prev = carry_reg[gi-1];
      assign v_prev = valid_reg[gi-1];
    end

    assign seg_add = {1'b0, a_prev[gi*SEG +: SEG]}
                   + {1'b0, b_prev[gi*SEG +: SEG]}
                   + {{SEG{1'b0}}, c_prev};

    always_comb begin
      s_tmp                  = s_prev;
      s_tmp[gi*SEG +: SEG]   = seg_add[SEG-1:0];
    end

    assign a_next[gi]     = a_prev;
    assign b_next[gi]     = b_prev;
    assign s_next[gi]     = s_tmp;
    assign carry_next[gi] = seg_add[SEG];
    assign valid_next[gi] = v_prev;
  end

  assign ovf_next = (a_next[LAST][MSB] == b_next[LAST][MSB])
                 && (s_next[LAST][MSB] != a_next[LAST][MSB]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSTAGES; k++) begin
        a_reg[k]     <= '0;
        b_reg[k]     <= '0;
        s_reg[k]     <= '0;
        carry_reg[k] <= 1'b0;
        valid_reg[k] <= 1'b0;
      end
      ovf_reg <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < NSTAGES; k++) begin
        a_reg[k]     <= a_next[k];
        b_reg[k]     <= b_next[k];
        s_reg[k]     <= s_next[k];
        carry_reg[k] <= carry_next[k];
        valid_reg[k] <= valid_next[k];
      end
      ovf_reg <= ovf_next;
    end
  end

  assign bus.out_valid = valid_reg[LAST];
  assign bus.sum       = s_reg[LAST];
  assign bus.c_out     = carry_reg[LAST];
  assign bus.overflow  = ovf_reg;
endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=8, SEG=4): driver pushes model results,
// a negedge monitor pops and compares them whenever a result transfers out.
module tb_pipelined_adder;
  localparam int W  = 8;
  localparam int SG = 4;
  localparam int NS = W / SG;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           cyc;
    bit           lat_chk;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sub_drv = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   lat_mode = 1'b0;
  bit   rand_ready = 1'b0;
  exp_t q[$];

  pipelined_adder_if #(.WIDTH(W)) bus ();

  pipelined_adder #(.WIDTH(W), .SEG(SG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef PIPELINED_ADDER_SUB_EN
  assign bus.sub = sub_drv;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact integer arithmetic, then wrap / range-test.
  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic sub);
    exp_t e;
    int ua = a;
    int ub = b;
    int ci = cin;
    int sa = $signed(a);
    int sb = $signed(b);
    int r;
    int sr;
    if (!sub) begin
      r = ua + ub + ci;
      sr = sa + sb + ci;
      e.cout = (r > (1 << W) - 1);
    end else begin
      r = ua - ub - ci;
      sr = sa - sb - ci;
      e.cout = (r >= 0);
    end
    e.sum = r[W-1:0];
    e.ovf = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
    e.cyc = 0;
    e.lat_chk = 1'b0;
    return e;
  endfunction

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: at negedge, handshake state describes what transfers at the next posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) begin
        exp_t e;
        e = model(bus.a, bus.b, bus.c_in, sub_drv);
        e.cyc = cyc;
        e.lat_chk = lat_mode;
        q.push_back(e);
        $display("IN  a=%02h b=%02h c_in=%0d sub=%0d exp_sum=%02h", bus.a, bus.b, bus.c_in, sub_drv, e.sum);
      end
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else if (!bus.out_ready) begin
          check("held_sum", bus.sum, q[0].sum);
          check("held_c_out", bus.c_out, q[0].cout);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("sum", bus.sum, e.sum);
          check("c_out", bus.c_out, e.cout);
          check("overflow", bus.overflow, e.ovf);
          if (e.lat_chk) check("latency", cyc - e.cyc, NS);
          $display("OUT sum=%02h c_out=%0d ovf=%0d exp=%02h/%0d/%0d", bus.sum, bus.c_out, bus.overflow, e.sum, e.cout, e.ovf);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic sub);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.c_in = cin;
    sub_drv = sub;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    bus.in_valid = 1'b0;
    bus.a = 'x;
    bus.b = 'x;
    bus.c_in = 1'bx;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.c_in = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_sum", bus.sum, 0);
    check("reset_c_out", bus.c_out, 0);
    check("reset_overflow", bus.overflow, 0);
    rst_n = 1'b1;
    idle(2);

    // Directed: carry across segment, wrap, signed overflow, then back-to-back.
    lat_mode = 1'b1;
    send(8'h0F, 8'h01, 1'b0, 1'b0); idle(4);
    send(8'hFF, 8'h01, 1'b0, 1'b0); idle(4);
    send(8'h7F, 8'h01, 1'b0, 1'b0); idle(4);
    send(8'h00, 8'h00, 1'b0, 1'b0);
    send(8'h00, 8'h00, 1'b1, 1'b0);
    send(8'h01, 8'h01, 1'b0, 1'b0);
    send(8'h01, 8'h01, 1'b1, 1'b0);
    idle(6);
    lat_mode = 1'b0;
    drain();

    // Backpressure with two results in flight.
    bus.out_ready = 1'b0;
    send(8'h12, 8'h34, 1'b0, 1'b0);
    send(8'hA5, 8'h5A, 1'b1, 1'b0);
    idle(0);
    for (int i = 0; i < 5; i++) begin
      check("stall_in_ready", bus.in_ready, 0);
      idle(1);
    end
    bus.out_ready = 1'b1;
    idle(4);
    drain();

    // Asynchronous reset with both stages holding valid data.
    bus.out_ready = 1'b0;
    send(8'h11, 8'h22, 1'b0, 1'b0);
    send(8'h33, 8'h44, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("async_rst_out_valid", bus.out_valid, 0);
    check("async_rst_in_ready", bus.in_ready, 1);
    idle(2);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("post_rst_no_output", bus.out_valid, 0);
      idle(1);
    end

`ifdef PIPELINED_ADDER_SUB_EN
    lat_mode = 1'b1;
    send(8'h05, 8'h07, 1'b0, 1'b1); idle(4);
    send(8'h80, 8'h01, 1'b0, 1'b1); idle(4);
    send(8'h09, 8'h03, 1'b1, 1'b1); idle(4);
    lat_mode = 1'b0;
    drain();
`endif

    // Randomised traffic with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
`ifdef PIPELINED_ADDER_SUB_EN
      send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
`else
      send(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
`endif
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(1);
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised successor to the single-bit full adder: a WIDTH-bit adder with carry-in, computed as a ripple of SEG-bit segments.
- One pipeline register per segment, so the carry chain is cut into NSTAGES = WIDTH/SEG stages for timing closure.
- valid/ready handshakes on input and output, with full-pipeline backpressure.
- Used as the datapath adder behind upstream stream sources.

Parameters:
- WIDTH, 32, operand/sum width in bits; must be ≥1.
- SEG, 8, bits added per pipeline stage; WIDTH % SEG must be 0, otherwise elaboration $error.
- NSTAGES (localparam), WIDTH/SEG, pipeline depth and latency in cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a, b, c_in valid this cycle.
- in_ready  output  1  adder accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in into bit 0.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  a + b + c_in, modulo 2^WIDTH.
- c_out  output  1  carry out of bit WIDTH-1.
- overflow  output  1  two's-complement signed overflow.

Behaviour:
- Reset (rst_n=0, asynchronous): all stage valid bits, out_valid, sum, c_out and overflow clear to 0; all data pipeline registers clear to 0. in_ready is 1 during and after reset.
- Advance condition: adv = !out_valid || out_ready.
  - in_ready = adv, combinational, no dependence on in_valid.
  - Transfer in = in_valid && in_ready. Transfer out = out_valid && out_ready.
- Pipeline move: when adv=1, every stage register loads from the stage before it, and the stage-0 valid bit loads in_valid. When adv=0, all stages hold, including bubbles; bubbles are not compressed.
- Stage k (0..NSTAGES-1) work:
  - Adds segment k of A and B plus the carry registered by stage k-1 (c_in for k=0).
  - Registers SEG result bits and the carry out.
  - Segments above k travel forward as delayed operands; segments below k travel forward as delayed result bits.
- Latency: a transfer in at edge t gives out_valid=1 after edge t+NSTAGES-1, when the last stage loads. Throughput is 1 result/cycle while out_ready=1.
- Outputs are registered from the final stage and stay stable while out_valid=1 && out_ready=0.
- Flag definitions:
  - c_out = carry out of the top segment.
  - overflow = (a[MSB]==b'[MSB]) && (sum[MSB]!=a[MSB]), where b' is the effective B operand.
- Simultaneous transfer in and transfer out in one cycle is legal, with no bubble inserted.
- Reset asserted mid-operation discards all in-flight results. Nothing is emitted after rst_n rises until a new input is accepted.
- X on a, b or c_in while in_valid=0 must not propagate into the valid bits.

Optional Feature:
- Macro: PIPELINED_ADDER_SUB_EN.
- With the macro defined:
  - Extra input port sub (1 bit), sampled with a and b on transfer in and carried down the pipeline.
  - sub=1: effective B = ~b and effective carry-in = ~c_in, giving a − b − c_in. c_out=1 means no borrow.
  - overflow uses the effective B.
  - sub=0: identical to the base behaviour.
- Without the macro: no sub port, addition only.

Test Plan (WIDTH=8, SEG=4, NSTAGES=2):
- Reset, then a=0x0F, b=0x01, c_in=0 with out_ready=1 → out_valid after 2 cycles; sum=0x10, c_out=0, overflow=0 (carry crosses the segment).
- a=0xFF, b=0x01, c_in=0 → sum=0x00, c_out=1, overflow=0. a=0x7F, b=0x01 → sum=0x80, c_out=0, overflow=1.
- Four back-to-back inputs, (0,0,0), (0,0,1), (1,1,0), (1,1,1) → sums 0x00, 0x01, 0x02, 0x03 on consecutive cycles, in order, all c_out=0.
- Backpressure: out_ready=0 for 5 cycles with 2 results in flight → in_ready=0 and sum held stable. Releasing out_ready → both results delivered in order, none lost or duplicated.
- Assert rst_n=0 asynchronously with 2 valid stages → out_valid=0 immediately and no stale output after release.
- With PIPELINED_ADDER_SUB_EN: sub=1, a=0x05, b=0x07, c_in=0 → sum=0xFE, c_out=0, overflow=0. sub=1, a=0x80, b=0x01 → sum=0x7F, overflow=1.
